// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the four-lane round-robin / fixed-priority
// output arbiter.
package mux_arb_pkg;

   localparam int N_LANES = 4;
   localparam int DATA_W  = 8;

   typedef logic [1:0] lane_idx_t;

   // IDLE: output register empty; SEND: word presented, downstream was
   // ready; HOLD: word presented and stalled by downstream.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_HOLD = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational lane selector. In round-robin mode the search starts at the
// lane after ptr and wraps; in fixed mode the lowest-numbered valid lane wins.
module rr_picker
   import mux_arb_pkg::*;
(
   input  logic [N_LANES-1:0] valid,
   input  lane_idx_t          ptr,
   input  logic               modo,
   output lane_idx_t          idx,
   output logic               any_valid
);

   lane_idx_t cand_s;

   // Priority search; later loop iterations overwrite earlier ones, so the
   // loop runs from lowest to highest priority.
   always_comb begin
      idx    = 2'd0;
      cand_s = 2'd0;
      if (modo) begin
         for (int i = N_LANES - 1; i >= 0; i--) begin
            if (valid[i]) begin
               idx = lane_idx_t'(i);
            end else begin
               idx = idx;
            end
         end
      end else begin
         // k = N_LANES wraps back to ptr itself (lowest priority),
         // k = 1 is the lane right after ptr (highest priority).
         for (int k = N_LANES; k >= 1; k--) begin
            cand_s = ptr + lane_idx_t'(k);
            if (valid[cand_s]) begin
               idx = cand_s;
            end else begin
               idx = idx;
            end
         end
      end
   end

   assign any_valid = |valid;

endmodule

// File: rtl/mux_arbiter_rr.sv
// Four-lane to one output arbiter with a single registered output stage.
// modo=0: round-robin with up to BURST consecutive words per lane.
// modo=1: fixed priority, lane 0 highest.
module mux_arbiter_rr
   import mux_arb_pkg::*;
#(
   parameter int BURST = 1
)
(
   input  logic              clk_4f,
   input  logic              reset,
   input  logic              validEntrada0,
   input  logic              validEntrada1,
   input  logic              validEntrada2,
   input  logic              validEntrada3,
   input  logic [DATA_W-1:0] Entrada0,
   input  logic [DATA_W-1:0] Entrada1,
   input  logic [DATA_W-1:0] Entrada2,
   input  logic [DATA_W-1:0] Entrada3,
   output logic              readyEntrada0,
   output logic              readyEntrada1,
   output logic              readyEntrada2,
   output logic              readyEntrada3,
   input  logic              modo,
   input  logic              readySalida,
   output logic [DATA_W-1:0] Salida,
   output logic              validSalida,
   output logic [1:0]        grant_id
);

   localparam logic [3:0] BURST_C = 4'(BURST);

   arb_state_e          state_r;
   arb_state_e          state_nxt_s;
   logic [DATA_W-1:0]   salida_r;
   lane_idx_t           grant_r;
   lane_idx_t           ptr_r;
   logic [3:0]          burst_cnt_r;

   logic [N_LANES-1:0]  valid_s;
   logic [N_LANES-1:0]  ready_s;
   lane_idx_t           pick_idx_s;
   logic                pick_any_s;
   logic                keep_s;
   lane_idx_t           sel_idx_s;
   logic                load_en_s;
   logic                xfer_s;
   logic [DATA_W-1:0]   sel_data_s;

   assign valid_s = {validEntrada3, validEntrada2, validEntrada1, validEntrada0};

   rr_picker u_rr_picker (
      .valid     (valid_s),
      .ptr       (ptr_r),
      .modo      (modo),
      .idx       (pick_idx_s),
      .any_valid (pick_any_s)
   );

   // Stay on the current lane while its burst allowance lasts; burst_cnt
   // of zero means no lane owns the output yet (after reset).
   always_comb begin
      if (!modo && (burst_cnt_r != 4'd0) && (burst_cnt_r < BURST_C) && valid_s[ptr_r]) begin
         keep_s = 1'b1;
      end else begin
         keep_s = 1'b0;
      end
   end

   assign sel_idx_s = keep_s ? ptr_r : pick_idx_s;
   assign load_en_s = (state_r == ST_IDLE) || readySalida;
   assign xfer_s    = load_en_s && pick_any_s && !reset;

   // Data of the selected lane.
   always_comb begin
      case (sel_idx_s)
         2'd0:    sel_data_s = Entrada0;
         2'd1:    sel_data_s = Entrada1;
         2'd2:    sel_data_s = Entrada2;
         2'd3:    sel_data_s = Entrada3;
         default: sel_data_s = {DATA_W{1'b0}};
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state: a stalled word holds, otherwise the stage refills or empties.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (xfer_s) begin
               state_nxt_s = ST_SEND;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SEND, ST_HOLD: begin
            if (!readySalida) begin
               state_nxt_s = ST_HOLD;
            end else if (xfer_s) begin
               state_nxt_s = ST_SEND;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM outputs: one-hot ready towards the selected lane only on a transfer.
   always_comb begin
      ready_s = 4'b0000;
      if (xfer_s) begin
         ready_s[sel_idx_s] = 1'b1;
      end else begin
         ready_s = 4'b0000;
      end
   end

   // Output register, round-robin pointer and burst counter.
   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         salida_r    <= 8'h00;
         grant_r     <= 2'd0;
         ptr_r       <= 2'd3;
         burst_cnt_r <= 4'd0;
      end else if (xfer_s) begin
         salida_r <= sel_data_s;
         grant_r  <= sel_idx_s;
         ptr_r    <= sel_idx_s;
         if (sel_idx_s == ptr_r) begin
            // Saturate so a long fixed-priority run cannot wrap to zero.
            if (burst_cnt_r != 4'hF) begin
               burst_cnt_r <= burst_cnt_r + 4'd1;
            end else begin
               burst_cnt_r <= burst_cnt_r;
            end
         end else begin
            burst_cnt_r <= 4'd1;
         end
      end else begin
         salida_r    <= salida_r;
         grant_r     <= grant_r;
         ptr_r       <= ptr_r;
         burst_cnt_r <= burst_cnt_r;
      end
   end

   assign Salida        = salida_r;
   assign grant_id      = grant_r;
   assign validSalida   = (state_r != ST_IDLE);
   assign readyEntrada0 = ready_s[0];
   assign readyEntrada1 = ready_s[1];
   assign readyEntrada2 = ready_s[2];
   assign readyEntrada3 = ready_s[3];

endmodule

// File: tb/tb_mux_arbiter_rr.sv
// Directed bench for mux_arbiter_rr: one instance with BURST=1 and one with
// BURST=3 share all inputs.
module tb_mux_arbiter_rr;
   import mux_arb_pkg::*;

   logic       clk_4f;
   logic       reset;
   logic       v0, v1, v2, v3;
   logic [7:0] e0, e1, e2, e3;
   logic       modo;
   logic       readySalida;

   logic       r1_0, r1_1, r1_2, r1_3;
   logic [7:0] sal1;
   logic       vs1;
   logic [1:0] g1;
   logic       r3_0, r3_1, r3_2, r3_3;
   logic [7:0] sal3;
   logic       vs3;
   logic [1:0] g3;

   logic [3:0] rdy1, rdy3;
   assign rdy1 = {r1_3, r1_2, r1_1, r1_0};
   assign rdy3 = {r3_3, r3_2, r3_1, r3_0};

   int cmp_cnt;
   int bad_cnt;

   mux_arbiter_rr #(.BURST(1)) dut (
      .clk_4f(clk_4f), .reset(reset),
      .validEntrada0(v0), .validEntrada1(v1), .validEntrada2(v2), .validEntrada3(v3),
      .Entrada0(e0), .Entrada1(e1), .Entrada2(e2), .Entrada3(e3),
      .readyEntrada0(r1_0), .readyEntrada1(r1_1), .readyEntrada2(r1_2), .readyEntrada3(r1_3),
      .modo(modo), .readySalida(readySalida),
      .Salida(sal1), .validSalida(vs1), .grant_id(g1)
   );

   mux_arbiter_rr #(.BURST(3)) dut3 (
      .clk_4f(clk_4f), .reset(reset),
      .validEntrada0(v0), .validEntrada1(v1), .validEntrada2(v2), .validEntrada3(v3),
      .Entrada0(e0), .Entrada1(e1), .Entrada2(e2), .Entrada3(e3),
      .readyEntrada0(r3_0), .readyEntrada1(r3_1), .readyEntrada2(r3_2), .readyEntrada3(r3_3),
      .modo(modo), .readySalida(readySalida),
      .Salida(sal3), .validSalida(vs3), .grant_id(g3)
   );

   initial clk_4f = 1'b0;
   always #5 clk_4f = ~clk_4f;

   task automatic set_lanes(input logic [3:0] v);
      v0 = v[0]; v1 = v[1]; v2 = v[2]; v3 = v[3];
   endtask

   task automatic do_reset();
      @(negedge clk_4f);
      reset = 1'b1;
      @(negedge clk_4f);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_lanes(4'b1111);
      modo = 1'b0;
      readySalida = 1'b1;
      @(negedge clk_4f);
      @(negedge clk_4f);
      cmp_cnt++; if (vs1 !== 1'b0) begin bad_cnt++; $display("FAIL reset_valid got %b exp 0", vs1); end
      cmp_cnt++; if (sal1 !== 8'h00) begin bad_cnt++; $display("FAIL reset_salida got %h exp 00", sal1); end
      cmp_cnt++; if (g1 !== 2'd0) begin bad_cnt++; $display("FAIL reset_grant got %0d exp 0", g1); end
      cmp_cnt++; if (rdy1 !== 4'b0000) begin bad_cnt++; $display("FAIL reset_ready got %b exp 0000", rdy1); end
      cmp_cnt++; if (dut.ptr_r !== 2'd3) begin bad_cnt++; $display("FAIL reset_ptr got %0d exp 3", dut.ptr_r); end
      cmp_cnt++; if (dut.burst_cnt_r !== 4'd0) begin bad_cnt++; $display("FAIL reset_burst got %0d exp 0", dut.burst_cnt_r); end
      cmp_cnt++; if (dut.state_r !== ST_IDLE) begin bad_cnt++; $display("FAIL reset_state got %0d exp IDLE", dut.state_r); end
      reset = 1'b0;
   endtask

   // BURST=1 rotates every word; BURST=3 gives each lane three words.
   task automatic test_round_robin();
      logic [1:0] exp_g1 [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      logic [1:0] exp_g3 [10] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
      logic [7:0] lane_data [4] = '{8'hEE, 8'h01, 8'hFF, 8'hFD};
      set_lanes(4'b1111);
      modo = 1'b0;
      readySalida = 1'b1;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         #1;
         cmp_cnt++; if (rdy1 !== (4'b0001 << exp_g1[i])) begin bad_cnt++; $display("FAIL rr_ready1[%0d] got %b exp lane %0d", i, rdy1, exp_g1[i]); end
         cmp_cnt++; if (rdy3 !== (4'b0001 << exp_g3[i])) begin bad_cnt++; $display("FAIL rr_ready3[%0d] got %b exp lane %0d", i, rdy3, exp_g3[i]); end
         @(negedge clk_4f);
         cmp_cnt++; if (g1 !== exp_g1[i]) begin bad_cnt++; $display("FAIL rr_grant1[%0d] got %0d exp %0d", i, g1, exp_g1[i]); end
         cmp_cnt++; if (sal1 !== lane_data[exp_g1[i]]) begin bad_cnt++; $display("FAIL rr_salida1[%0d] got %h exp %h", i, sal1, lane_data[exp_g1[i]]); end
         cmp_cnt++; if (vs1 !== 1'b1) begin bad_cnt++; $display("FAIL rr_valid1[%0d] got %b exp 1", i, vs1); end
         cmp_cnt++; if (g3 !== exp_g3[i]) begin bad_cnt++; $display("FAIL burst3_grant[%0d] got %0d exp %0d", i, g3, exp_g3[i]); end
      end
   endtask

   task automatic test_fixed_priority();
      set_lanes(4'b1111);
      modo = 1'b1;
      readySalida = 1'b1;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         #1;
         cmp_cnt++; if (rdy1 !== 4'b0001) begin bad_cnt++; $display("FAIL fixed_ready[%0d] got %b exp 0001", i, rdy1); end
         @(negedge clk_4f);
         cmp_cnt++; if (sal1 !== 8'hEE) begin bad_cnt++; $display("FAIL fixed_salida[%0d] got %h exp EE", i, sal1); end
         cmp_cnt++; if (g1 !== 2'd0) begin bad_cnt++; $display("FAIL fixed_grant[%0d] got %0d exp 0", i, g1); end
      end
   endtask

   task automatic test_stall();
      set_lanes(4'b1111);
      modo = 1'b0;
      readySalida = 1'b1;
      do_reset();
      @(negedge clk_4f);
      readySalida = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         cmp_cnt++; if (rdy1 !== 4'b0000) begin bad_cnt++; $display("FAIL stall_ready1[%0d] got %b exp 0000", i, rdy1); end
         cmp_cnt++; if (rdy3 !== 4'b0000) begin bad_cnt++; $display("FAIL stall_ready3[%0d] got %b exp 0000", i, rdy3); end
         @(negedge clk_4f);
         cmp_cnt++; if (sal1 !== 8'hEE || g1 !== 2'd0 || vs1 !== 1'b1) begin bad_cnt++; $display("FAIL stall_hold[%0d] got %h/%0d/%b exp EE/0/1", i, sal1, g1, vs1); end
         cmp_cnt++; if (dut.state_r !== ST_HOLD) begin bad_cnt++; $display("FAIL stall_state[%0d] got %0d exp HOLD", i, dut.state_r); end
      end
      readySalida = 1'b1;
      #1;
      cmp_cnt++; if (rdy1 !== 4'b0010) begin bad_cnt++; $display("FAIL stall_release_ready got %b exp 0010", rdy1); end
      @(negedge clk_4f);
      cmp_cnt++; if (sal1 !== 8'h01 || g1 !== 2'd1) begin bad_cnt++; $display("FAIL stall_next got %h/%0d exp 01/1", sal1, g1); end
      @(negedge clk_4f);
      cmp_cnt++; if (sal1 !== 8'hFF || g1 !== 2'd2) begin bad_cnt++; $display("FAIL stall_next2 got %h/%0d exp FF/2", sal1, g1); end
   endtask

   task automatic test_modo_switch();
      set_lanes(4'b1111);
      modo = 1'b0;
      readySalida = 1'b1;
      do_reset();
      @(negedge clk_4f);
      @(negedge clk_4f);
      readySalida = 1'b0;
      modo = 1'b1;
      @(negedge clk_4f);
      cmp_cnt++; if (sal1 !== 8'h01 || g1 !== 2'd1 || vs1 !== 1'b1) begin bad_cnt++; $display("FAIL modo_held got %h/%0d/%b exp 01/1/1", sal1, g1, vs1); end
      readySalida = 1'b1;
      #1;
      cmp_cnt++; if (rdy1 !== 4'b0001) begin bad_cnt++; $display("FAIL modo_ready got %b exp 0001", rdy1); end
      @(negedge clk_4f);
      cmp_cnt++; if (sal1 !== 8'hEE || g1 !== 2'd0) begin bad_cnt++; $display("FAIL modo_next got %h/%0d exp EE/0", sal1, g1); end
   endtask

   task automatic test_single_lane();
      set_lanes(4'b0000);
      modo = 1'b0;
      readySalida = 1'b1;
      do_reset();
      set_lanes(4'b0100);
      #1;
      cmp_cnt++; if (rdy1 !== 4'b0100) begin bad_cnt++; $display("FAIL single_ready got %b exp 0100", rdy1); end
      @(negedge clk_4f);
      cmp_cnt++; if (sal1 !== 8'hFF || g1 !== 2'd2 || vs1 !== 1'b1) begin bad_cnt++; $display("FAIL single_word got %h/%0d/%b exp FF/2/1", sal1, g1, vs1); end
      set_lanes(4'b0000);
      #1;
      cmp_cnt++; if (rdy1 !== 4'b0000) begin bad_cnt++; $display("FAIL single_drop_ready got %b exp 0000", rdy1); end
      @(negedge clk_4f);
      cmp_cnt++; if (vs1 !== 1'b0) begin bad_cnt++; $display("FAIL single_empty_valid got %b exp 0", vs1); end
      cmp_cnt++; if (sal1 !== 8'hFF || g1 !== 2'd2) begin bad_cnt++; $display("FAIL single_empty_hold got %h/%0d exp FF/2", sal1, g1); end
      cmp_cnt++; if (dut.state_r !== ST_IDLE) begin bad_cnt++; $display("FAIL single_state got %0d exp IDLE", dut.state_r); end
   endtask

   task automatic test_reset_in_hold();
      set_lanes(4'b0000);
      modo = 1'b0;
      readySalida = 1'b1;
      do_reset();
      set_lanes(4'b0100);
      @(negedge clk_4f);
      readySalida = 1'b0;
      set_lanes(4'b1111);
      @(negedge clk_4f);
      cmp_cnt++; if (dut.state_r !== ST_HOLD || g1 !== 2'd2) begin bad_cnt++; $display("FAIL rsthold_pre got state %0d grant %0d exp HOLD/2", dut.state_r, g1); end
      #2;
      reset = 1'b1;
      #1;
      cmp_cnt++; if (vs1 !== 1'b0 || vs3 !== 1'b0) begin bad_cnt++; $display("FAIL rsthold_valid got %b/%b exp 0/0", vs1, vs3); end
      cmp_cnt++; if (sal1 !== 8'h00 || g1 !== 2'd0) begin bad_cnt++; $display("FAIL rsthold_out got %h/%0d exp 00/0", sal1, g1); end
      cmp_cnt++; if (rdy1 !== 4'b0000) begin bad_cnt++; $display("FAIL rsthold_ready got %b exp 0000", rdy1); end
      @(negedge clk_4f);
      reset = 1'b0;
      readySalida = 1'b1;
      #1;
      cmp_cnt++; if (rdy1 !== 4'b0001) begin bad_cnt++; $display("FAIL rsthold_first_ready got %b exp 0001", rdy1); end
      @(negedge clk_4f);
      cmp_cnt++; if (g1 !== 2'd0 || sal1 !== 8'hEE || vs1 !== 1'b1) begin bad_cnt++; $display("FAIL rsthold_first got %h/%0d/%b exp EE/0/1", sal1, g1, vs1); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      cmp_cnt = 0;
      bad_cnt = 0;
      e0 = 8'hEE; e1 = 8'h01; e2 = 8'hFF; e3 = 8'hFD;
      reset = 1'b1;
      set_lanes(4'b0000);
      modo = 1'b0;
      readySalida = 1'b0;
      test_reset();
      test_round_robin();
      test_fixed_priority();
      test_stall();
      test_modo_switch();
      test_single_lane();
      test_reset_in_hold();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
      $finish;
   end

endmodule
